// File: rtl/i2c_slave_rx_fsm.sv
// I2C slave receive engine: synchronises SCL/SDA/START, matches the address byte,
// ACKs and delivers write-data bytes on a strobe port, and flags read requests.
module i2c_slave_rx_fsm #(
    parameter logic [6:0]  DEV_ADDR    = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic       start_detected,
    input  logic       rx_ready,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       addr_match,
    output logic       rd_req,
    output logic       busy,
    output logic       stop_seen
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync, start_sync;
    logic                   scl_d, sda_d, start_d;
    logic                   scl_s, sda_s, start_s;
    logic                   scl_rise, scl_fall, start_evt, stop_evt;

    state_t     state, state_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [7:0] shift, shift_nx, shifted;
    logic       byte_done, byte_done_nx;
    logic       ack_phase, ack_phase_nx;
    logic       rw_bit, rw_bit_nx;
    logic       first_flag, first_flag_nx;
    logic       sda_oe_q, sda_oe_nx;
    logic       addr_match_q, addr_match_nx;
    logic [7:0] rx_data_q, rx_data_nx;
    logic       rx_valid_q, rx_valid_nx;
    logic       rx_first_q, rx_first_nx;
    logic       rd_req_q, rd_req_nx;
    logic       stop_seen_q, stop_seen_nx;

    // Idle bus levels on reset so leaving reset never fakes an edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_sync   <= '1;
            sda_sync   <= '1;
            start_sync <= '0;
            scl_d      <= 1'b1;
            sda_d      <= 1'b1;
            start_d    <= 1'b0;
        end else begin
            scl_sync   <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync   <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            start_sync <= {start_sync[SYNC_STAGES-2:0], start_detected};
            scl_d      <= scl_s;
            sda_d      <= sda_s;
            start_d    <= start_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign start_s   = start_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_evt = start_s & ~start_d;
    assign stop_evt  = sda_s & ~sda_d & scl_s;
    assign shifted   = {shift[6:0], sda_s};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            bit_cnt      <= 3'd0;
            shift        <= 8'h00;
            byte_done    <= 1'b0;
            ack_phase    <= 1'b0;
            rw_bit       <= 1'b0;
            first_flag   <= 1'b0;
            sda_oe_q     <= 1'b0;
            addr_match_q <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_first_q   <= 1'b0;
            rd_req_q     <= 1'b0;
            stop_seen_q  <= 1'b0;
        end else begin
            state        <= state_nx;
            bit_cnt      <= bit_cnt_nx;
            shift        <= shift_nx;
            byte_done    <= byte_done_nx;
            ack_phase    <= ack_phase_nx;
            rw_bit       <= rw_bit_nx;
            first_flag   <= first_flag_nx;
            sda_oe_q     <= sda_oe_nx;
            addr_match_q <= addr_match_nx;
            rx_data_q    <= rx_data_nx;
            rx_valid_q   <= rx_valid_nx;
            rx_first_q   <= rx_first_nx;
            rd_req_q     <= rd_req_nx;
            stop_seen_q  <= stop_seen_nx;
        end
    end

    // Repeated START outranks STOP; stop_seen still pulses when both coincide
    always_comb begin
        state_nx      = state;
        bit_cnt_nx    = bit_cnt;
        shift_nx      = shift;
        byte_done_nx  = byte_done;
        ack_phase_nx  = ack_phase;
        rw_bit_nx     = rw_bit;
        first_flag_nx = first_flag;
        sda_oe_nx     = sda_oe_q;
        addr_match_nx = addr_match_q;
        rx_data_nx    = rx_data_q;
        rx_valid_nx   = 1'b0;
        rx_first_nx   = 1'b0;
        rd_req_nx     = 1'b0;
        stop_seen_nx  = 1'b0;

        if (state != IDLE && stop_evt) begin
            stop_seen_nx = 1'b1;
        end

        if (start_evt) begin
            state_nx      = ADDR;
            bit_cnt_nx    = 3'd0;
            byte_done_nx  = 1'b0;
            ack_phase_nx  = 1'b0;
            first_flag_nx = 1'b0;
            sda_oe_nx     = 1'b0;
            addr_match_nx = 1'b0;
        end else if (state != IDLE && stop_evt) begin
            state_nx      = IDLE;
            bit_cnt_nx    = 3'd0;
            byte_done_nx  = 1'b0;
            ack_phase_nx  = 1'b0;
            first_flag_nx = 1'b0;
            sda_oe_nx     = 1'b0;
            addr_match_nx = 1'b0;
        end else begin
            case (state)
                IDLE: state_nx = IDLE;
                ADDR: begin
                    if (scl_rise) begin
                        shift_nx   = shifted;
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (shifted[7:1] == DEV_ADDR) begin
                                state_nx     = ADDR_ACK;
                                rw_bit_nx    = shifted[0];
                                ack_phase_nx = 1'b0;
                            end else begin
                                state_nx = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe_nx     = 1'b1;
                            addr_match_nx = 1'b1;
                            ack_phase_nx  = 1'b1;
                        end else begin
                            sda_oe_nx    = 1'b0;
                            ack_phase_nx = 1'b0;
                            if (rw_bit) begin
                                rd_req_nx = 1'b1;
                                state_nx  = IGNORE;
                            end else begin
                                first_flag_nx = 1'b1;
                                bit_cnt_nx    = 3'd0;
                                state_nx      = DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (byte_done) begin
                        if (scl_fall) begin
                            byte_done_nx = 1'b0;
                            if (rx_ready) begin
                                rx_valid_nx   = 1'b1;
                                rx_first_nx   = first_flag;
                                first_flag_nx = 1'b0;
                                sda_oe_nx     = 1'b1;
                                state_nx      = DATA_ACK;
                            end else begin
                                state_nx = IGNORE;
                            end
                        end
                    end else if (scl_rise) begin
                        shift_nx   = shifted;
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_done_nx = 1'b1;
                            rx_data_nx   = shifted;
                        end
                    end
                end
                DATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nx = 1'b0;
                        state_nx  = DATA;
                    end
                end
                IGNORE:  sda_oe_nx = 1'b0;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        sda_oe     = sda_oe_q;
        rx_data    = rx_data_q;
        rx_valid   = rx_valid_q;
        rx_first   = rx_first_q;
        addr_match = addr_match_q;
        rd_req     = rd_req_q;
        stop_seen  = stop_seen_q;
        busy       = (state != IDLE);
    end

endmodule
